regfile: RTL and testbench

Parametrised register file: the multi-register successor to the single 16-bit `reg16`. It provides one write port and two independently enabled, registered read ports (A and B) that feed the ALU operand buses. It also has a sequenced bulk-clear engine, so software can zero all registers without a full reset. Sits between the bus/write-back path and the datapath operand inputs.

---
 rtl/regfile.sv | 113 +++++++++++
 tb/tb_regfile.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Register file: one write port, two registered read ports and a sequenced bulk-clear engine.
// Optional feature: define REGFILE_BYPASS_EN for write-through forwarding on read/write collisions.
module regfile #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re_a,
  input  logic [AW-1:0]    i_raddr_a,
  input  logic             i_re_b,
  input  logic [AW-1:0]    i_raddr_b,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b,
  output logic             o_busy
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata_a;
  logic [WIDTH-1:0] r_rdata_b;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic             w_idle;
  logic             w_wr_en;

  assign w_idle  = (r_state == StIdle);
  assign w_wr_en = i_we && w_idle;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      StIdle: begin
        if (i_clr) begin
          w_state_nxt = StClear;
          w_ptr_nxt   = '0;
        end
      end
      StClear: begin
        // clr is ignored here: the sweep always runs to completion exactly once
        if (r_ptr == LastPtr) begin
          w_state_nxt = StIdle;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end else if (r_state == StClear) begin
      r_mem[r_ptr] <= '0;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward only genuine writes; sweep zeroes are never forwarded.
  assign w_rd_a = (w_wr_en && (i_raddr_a == i_waddr)) ? i_wdata : r_mem[i_raddr_a];
  assign w_rd_b = (w_wr_en && (i_raddr_b == i_waddr)) ? i_wdata : r_mem[i_raddr_b];
`else
  assign w_rd_a = r_mem[i_raddr_a];
  assign w_rd_b = r_mem[i_raddr_b];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      if (i_re_a) r_rdata_a <= w_rd_a;
      if (i_re_b) r_rdata_b <= w_rd_b;
    end
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;
  assign o_busy    = (r_state == StClear);

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile (WIDTH=16, DEPTH=8): vector table plus clear/reset sequences.
module tb_regfile;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

`ifdef REGFILE_BYPASS_EN
  localparam logic [15:0] RdwExp = 16'h5555;
`else
  localparam logic [15:0] RdwExp = 16'hAAAA;
`endif

  logic             clk;
  logic             rst_n;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             re_a;
  logic [AW-1:0]    raddr_a;
  logic             re_b;
  logic [AW-1:0]    raddr_b;
  logic             clr;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             busy;

  int checks = 0;
  int errors = 0;

  regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_we      (we),
    .i_waddr   (waddr),
    .i_wdata   (wdata),
    .i_re_a    (re_a),
    .i_raddr_a (raddr_a),
    .i_re_b    (re_b),
    .i_raddr_b (raddr_b),
    .i_clr     (clr),
    .o_rdata_a (rdata_a),
    .o_rdata_b (rdata_b),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        re_a;
    logic [2:0]  raddr_a;
    logic        re_b;
    logic [2:0]  raddr_b;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(logic w, logic [2:0] wa, logic [15:0] wd, logic ra_en,
                              logic [2:0] ra, logic rb_en, logic [2:0] rb,
                              logic [15:0] ea, logic [15:0] eb);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd;
    v.re_a = ra_en; v.raddr_a = ra; v.re_b = rb_en; v.raddr_b = rb;
    v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0; clr = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 16'(16'h1111 * (i + 1));
      tick();
    end
    we = 1'b0;
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 8; i++) begin
      re_a = 1'b1; raddr_a = 3'(i); re_b = 1'b1; raddr_b = 3'(7 - i);
      tick();
      check({name, "_a"}, rdata_a, 16'h0000);
      check({name, "_b"}, rdata_b, 16'h0000);
    end
    re_a = 1'b0; re_b = 1'b0;
  endtask

  int n;

  initial begin
    vecs[0] = mk(1, 3, 16'hF0F0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    vecs[1] = mk(1, 5, 16'hCCCC, 0, 0, 0, 0, 16'h0000, 16'h0000);
    vecs[2] = mk(0, 0, 16'h0000, 1, 3, 1, 5, 16'hF0F0, 16'hCCCC);
    vecs[3] = mk(1, 3, 16'h1234, 0, 3, 0, 5, 16'hF0F0, 16'hCCCC);
    vecs[4] = mk(1, 2, 16'hAAAA, 0, 0, 0, 0, 16'hF0F0, 16'hCCCC);
    vecs[5] = mk(1, 2, 16'h5555, 1, 2, 0, 0, RdwExp,   16'hCCCC);
    vecs[6] = mk(0, 0, 16'h0000, 1, 2, 1, 3, 16'h5555, 16'h1234);
    vecs[7] = mk(0, 0, 16'h0000, 1, 4, 1, 4, 16'h0000, 16'h0000);
    vecs[8] = mk(0, 0, 16'h0000, 1, 5, 1, 5, 16'hCCCC, 16'hCCCC);

    idle_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();

    check("reset_busy", {15'b0, busy}, 16'h0000);
    read_all_zero("reset_read");

    for (int i = 0; i < 9; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      re_a = vecs[i].re_a; raddr_a = vecs[i].raddr_a;
      re_b = vecs[i].re_b; raddr_b = vecs[i].raddr_b;
      tick();
      check($sformatf("vec%0d_a", i), rdata_a, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), rdata_b, vecs[i].exp_b);
    end
    idle_inputs();

    // Bulk clear while watching r7 on port A.
    fill();
    clr = 1'b1; re_a = 1'b1; raddr_a = 3'd7;
    tick();
    clr = 1'b0;
    check("clr_busy_0", {15'b0, busy}, 16'h0001);
    check("clr_r7_0", rdata_a, 16'h8888);
    for (int k = 1; k <= 8; k++) begin
      we = (k == 2); waddr = 3'd1; wdata = 16'hBEEF;
      clr = (k == 4);
      tick();
      check($sformatf("clr_busy_%0d", k), {15'b0, busy}, (k <= 7) ? 16'h0001 : 16'h0000);
      check($sformatf("clr_r7_%0d", k), rdata_a, 16'h8888);
    end
    idle_inputs();
    re_a = 1'b1; raddr_a = 3'd7;
    tick();
    check("clr_r7_after", rdata_a, 16'h0000);
    read_all_zero("clr_read");

    // Write accepted once the sweep is done.
    we = 1'b1; waddr = 3'd6; wdata = 16'h0F0F;
    tick();
    we = 1'b0; re_b = 1'b1; raddr_b = 3'd6;
    tick();
    check("post_clr_write", rdata_b, 16'h0F0F);
    idle_inputs();

    // Reset in the 4th busy cycle.
    fill();
    re_a = 1'b1; raddr_a = 3'd5; re_b = 1'b1; raddr_b = 3'd2;
    clr = 1'b1;
    tick();
    clr = 1'b0; re_a = 1'b0; re_b = 1'b0;
    check("rmc_pre_a", rdata_a, 16'h6666);
    check("rmc_pre_b", rdata_b, 16'h3333);
    tick(); tick(); tick();
    check("rmc_busy_pre", {15'b0, busy}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("rmc_busy", {15'b0, busy}, 16'h0000);
    check("rmc_rdata_a", rdata_a, 16'h0000);
    check("rmc_rdata_b", rdata_b, 16'h0000);
    #2;
    rst_n = 1'b1;
    read_all_zero("rmc_read");

    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    check("rmc_sweep_len", 16'(n), 16'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
